frame_difference_mask: RTL and testbench

Streaming foreground detector placed directly downstream of the per-pixel background model. Each cycle it takes the current RGB frame pixel and the co-timed background pixel and computes the sum of the three per-channel absolute differences. It compares that sum against a per-frame latched threshold and emits a 1-bit foreground mask with sync signals realigned. It also reports a per-frame foreground pixel count at each vertical sync.

---
 rtl/frame_difference_mask_pkg.sv | 29 ++
 rtl/frame_difference_mask_if.sv | 33 +++
 rtl/frame_difference_mask_abs_diff.sv | 33 +++
 rtl/frame_difference_mask.sv | 140 ++++++++++++++
 tb/tb_frame_difference_mask.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/frame_difference_mask_pkg.sv
// Shared constants, state encoding and helpers for the frame-difference
// foreground detector.
package frame_difference_pkg;

  localparam int PIX_W   = 8;
  localparam int RGB_W   = 24;
  localparam int SUM_W   = 10;
  localparam int LATENCY = 3;
  localparam logic [SUM_W-1:0] THR_RESET = 10'h3FF;

  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } fd_state_e;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } sync_t;

  // Zero-extended three-way add; 3 x 255 = 765 always fits in SUM_W bits.
  function automatic logic [SUM_W-1:0] sum3(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    return {2'b00, a} + {2'b00, b} + {2'b00, c};
  endfunction

endpackage

// File: rtl/frame_difference_mask_if.sv
// Pixel-stream bundle of the frame-difference detector: input video and
// threshold, realigned output video, mask and frame statistics.
interface frame_difference_mask_if
  import frame_difference_pkg::*;
#(
  parameter int COUNT_W = 22
) ();

  logic               in_de;
  logic               in_hsync;
  logic               in_vsync;
  logic [RGB_W-1:0]   frame_rgb;
  logic [RGB_W-1:0]   background_rgb;
  logic [SUM_W-1:0]   threshold;

  logic               out_de;
  logic               out_hsync;
  logic               out_vsync;
  logic               out_mask;
  logic [COUNT_W-1:0] fg_count;
  logic               fg_count_valid;

  modport master (
    output in_de, in_hsync, in_vsync, frame_rgb, background_rgb, threshold,
    input  out_de, out_hsync, out_vsync, out_mask, fg_count, fg_count_valid
  );

  modport slave (
    input  in_de, in_hsync, in_vsync, frame_rgb, background_rgb, threshold,
    output out_de, out_hsync, out_vsync, out_mask, fg_count, fg_count_valid
  );

endinterface

// File: rtl/frame_difference_mask_abs_diff.sv
// Registered unsigned 8-bit absolute difference, one cycle of latency.
module abs_diff_u8
  import frame_difference_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] diff_r
);

  logic [PIX_W-1:0] diff_s;

  // Subtract the smaller operand from the larger so no sign bit is needed.
  always_comb begin
    diff_s = '0;
    if (a >= b) begin
      diff_s = a - b;
    end else begin
      diff_s = b - a;
    end
  end

  // Result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_r <= '0;
    end else begin
      diff_r <= diff_s;
    end
  end

endmodule

// File: rtl/frame_difference_mask.sv
// Streaming foreground detector: SAD of current vs background pixel against a
// per-frame threshold, with sync realignment and per-frame foreground counts.
module frame_difference_mask
  import frame_difference_pkg::*;
#(
  parameter int COUNT_W = 22
) (
  input logic                    clk,
  input logic                    rst_n,
  frame_difference_mask_if.slave bus
);

  localparam int SYNC_STAGES = LATENCY - 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [PIX_W-1:0]   diff_r [3];
  logic [SUM_W-1:0]   sum_r;
  sync_t              sync_r [SYNC_STAGES];
  logic               vsync_in_prev_r;
  logic [SUM_W-1:0]   thr_q_r;
  fd_state_e          state_r;
  fd_state_e          state_next_s;
  logic [COUNT_W-1:0] cnt_r;
  logic [COUNT_W-1:0] cnt_next_s;
  logic [COUNT_W-1:0] fg_count_next_s;
  logic               valid_next_s;
  logic               mask_next_s;
  logic               vs_rise_s;

  for (genvar ch = 0; ch < 3; ch++) begin : g_chan
    abs_diff_u8 u_abs (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (bus.frame_rgb[ch*PIX_W +: PIX_W]),
      .b      (bus.background_rgb[ch*PIX_W +: PIX_W]),
      .diff_r (diff_r[ch])
    );
  end

  // Channel sum and the sync delay line that keeps de/hsync/vsync aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sum_r           <= sum3(diff_r[2], diff_r[1], diff_r[0]);
      sync_r[0].de    <= bus.in_de;
      sync_r[0].hsync <= bus.in_hsync;
      sync_r[0].vsync <= bus.in_vsync;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // The threshold only changes on an input vsync rising edge, so a frame in
  // flight always sees one value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_in_prev_r <= 1'b0;
      thr_q_r         <= THR_RESET;
    end else begin
      vsync_in_prev_r <= bus.in_vsync;
      if (bus.in_vsync && !vsync_in_prev_r) begin
        thr_q_r <= bus.threshold;
      end
    end
  end

  assign mask_next_s = sync_r[SYNC_STAGES-1].de && (sum_r > thr_q_r);
  assign vs_rise_s   = sync_r[SYNC_STAGES-1].vsync && !bus.out_vsync;

  // Output stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_de    <= 1'b0;
      bus.out_hsync <= 1'b0;
      bus.out_vsync <= 1'b0;
      bus.out_mask  <= 1'b0;
    end else begin
      bus.out_de    <= sync_r[SYNC_STAGES-1].de;
      bus.out_hsync <= sync_r[SYNC_STAGES-1].hsync;
      bus.out_vsync <= sync_r[SYNC_STAGES-1].vsync;
      bus.out_mask  <= mask_next_s;
    end
  end

  // Counting on the mask as it enters the output register means the pixel
  // that lands in the report cycle starts the next frame's count.
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    fg_count_next_s = bus.fg_count;
    valid_next_s    = 1'b0;
    case (state_r)
      WAIT_SYNC: begin
        if (vs_rise_s) begin
          state_next_s = RUN;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s   = cnt_r;
        end
      end
      RUN: begin
        if (vs_rise_s) begin
          fg_count_next_s = cnt_r;
          valid_next_s    = 1'b1;
          cnt_next_s      = mask_next_s ? CNT_ONE : '0;
        end else if (mask_next_s && (cnt_r != CNT_MAX)) begin
          cnt_next_s = cnt_r + CNT_ONE;
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      default: begin
        state_next_s = WAIT_SYNC;
        cnt_next_s   = '0;
      end
    endcase
  end

  // FSM, counter and report registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= WAIT_SYNC;
      cnt_r              <= '0;
      bus.fg_count       <= '0;
      bus.fg_count_valid <= 1'b0;
    end else begin
      state_r            <= state_next_s;
      cnt_r              <= cnt_next_s;
      bus.fg_count       <= fg_count_next_s;
      bus.fg_count_valid <= valid_next_s;
    end
  end

endmodule

// File: tb/tb_frame_difference_mask.sv
// Randomized bench for frame_difference_mask against a frame-level reference
// model; a second instance with a 4-bit counter exercises saturation.
module tb_frame_difference_mask;
  import frame_difference_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_difference_mask_if #(.COUNT_W(22)) bus ();
  frame_difference_mask_if #(.COUNT_W(4))  bus4 ();

  assign bus4.in_de          = bus.in_de;
  assign bus4.in_hsync       = bus.in_hsync;
  assign bus4.in_vsync       = bus.in_vsync;
  assign bus4.frame_rgb      = bus.frame_rgb;
  assign bus4.background_rgb = bus.background_rgb;
  assign bus4.threshold      = bus.threshold;

  frame_difference_mask #(.COUNT_W(22)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  frame_difference_mask #(.COUNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    logic de;
    logic hs;
    logic vs;
    logic mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state: latched threshold, frame bookkeeping on the output stream.
  int   m_thr;
  logic m_in_vs_prev;
  logic m_out_vs_prev;
  bit   m_running;
  int   m_cnt;
  int   m_fg_count;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check_outputs(input exp_t e);
    logic rise;
    logic exp_valid;
    check_eq("out_de",    bus.out_de,    e.de);
    check_eq("out_hsync", bus.out_hsync, e.hs);
    check_eq("out_vsync", bus.out_vsync, e.vs);
    check_eq("out_mask",  bus.out_mask,  e.mask);
    rise      = e.vs && !m_out_vs_prev;
    exp_valid = rise && m_running;
    if (rise) begin
      if (m_running) begin
        m_fg_count = m_cnt;
        m_cnt      = e.mask ? 1 : 0;
      end else begin
        m_cnt = 0;
      end
      m_running = 1'b1;
    end else if (m_running && e.mask) begin
      m_cnt++;
    end
    m_out_vs_prev = e.vs;
    check_eq("fg_count_valid",   bus.fg_count_valid,  exp_valid);
    check_eq("fg_count",         bus.fg_count,        m_fg_count);
    check_eq("fg_count_valid_4", bus4.fg_count_valid, exp_valid);
    check_eq("fg_count_4",       bus4.fg_count,       sat4(m_fg_count));
  endtask

  task automatic drive(input logic de, input logic hs, input logic vs,
                       input logic [23:0] f, input logic [23:0] b, input logic [9:0] thr);
    exp_t e;
    int   s;
    bus.in_de          = de;
    bus.in_hsync       = hs;
    bus.in_vsync       = vs;
    bus.frame_rgb      = f;
    bus.background_rgb = b;
    bus.threshold      = thr;
    if (vs && !m_in_vs_prev) m_thr = int'(thr);
    m_in_vs_prev = vs;
    s = absd(int'(f[23:16]), int'(b[23:16])) + absd(int'(f[15:8]), int'(b[15:8]))
      + absd(int'(f[7:0]), int'(b[7:0]));
    e.de   = de;
    e.hs   = hs;
    e.vs   = vs;
    e.mask = de && (s > m_thr);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check_outputs(e);
    end
  endtask

  function automatic logic [9:0] rthr();
    return 10'($urandom_range(0, 1023));
  endfunction

  task automatic pixel(input logic de, input logic [23:0] f, input logic [23:0] b);
    drive(de, 1'b0, 1'b0, f, b, rthr());
  endtask

  task automatic hblank();
    repeat (2) drive(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, rthr());
  endtask

  task automatic vsync_block(input logic [9:0] thr);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, rthr());
    repeat (2) drive(1'b0, 1'b0, 1'b1, 24'h0, 24'h0, thr);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, rthr());
  endtask

  task automatic apply_reset();
    exp_t z;
    #2;
    rst_n              = 1'b0;
    bus.in_de          = 1'b0;
    bus.in_hsync       = 1'b0;
    bus.in_vsync       = 1'b0;
    bus.frame_rgb      = 24'h0;
    bus.background_rgb = 24'h0;
    bus.threshold      = 10'h0;
    #1;
    check_eq("rst_out_de",     bus.out_de,         32'd0);
    check_eq("rst_out_hsync",  bus.out_hsync,      32'd0);
    check_eq("rst_out_vsync",  bus.out_vsync,      32'd0);
    check_eq("rst_out_mask",   bus.out_mask,       32'd0);
    check_eq("rst_valid",      bus.fg_count_valid, 32'd0);
    check_eq("rst_fg_count",   bus.fg_count,       32'd0);
    check_eq("rst_fg_count_4", bus4.fg_count,      32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_thr         = 1023;
    m_in_vs_prev  = 1'b0;
    m_out_vs_prev = 1'b0;
    m_running     = 1'b0;
    m_cnt         = 0;
    m_fg_count    = 0;
    z.de = 1'b0; z.hs = 1'b0; z.vs = 1'b0; z.mask = 1'b0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  task automatic random_frame(input int lines, input int width);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < width; p++) begin
        pixel(1'($urandom_range(0, 3) != 0), 24'($urandom()), 24'($urandom()));
      end
      hblank();
    end
  endtask

  initial begin
    apply_reset();

    // Before any vsync the threshold is at its reset value: nothing is foreground.
    repeat (3) pixel(1'b1, 24'hFFFFFF, 24'h000000);

    vsync_block(10'd19);
    repeat (3) pixel(1'b1, {8'd100, 8'd50, 8'd200}, {8'd90, 8'd60, 8'd200});
    hblank();
    repeat (3) pixel(1'b0, 24'hFFFFFF, 24'h000000);

    vsync_block(10'd20);
    repeat (3) pixel(1'b1, {8'd100, 8'd50, 8'd200}, {8'd90, 8'd60, 8'd200});

    // Threshold input moves to 10 mid-frame; the latched 100 must still hold.
    vsync_block(10'd100);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, {8'd50, 8'd0, 8'd0}, 24'h0, 10'd10);
    vsync_block(10'd10);
    repeat (4) pixel(1'b1, {8'd50, 8'd0, 8'd0}, 24'h0);

    // Frame with exactly 37 foreground pixels.
    vsync_block(10'd50);
    for (int i = 0; i < 60; i++) begin
      if (i % 7 == 3) pixel(1'b0, 24'hFFFFFF, 24'h0);
      pixel(1'b1, (i < 37) ? {8'd200, 8'd0, 8'd0} : {8'd10, 8'd0, 8'd0}, 24'h0);
    end
    vsync_block(10'd764);
    check_eq("count37",     bus.fg_count,  32'd37);
    check_eq("count37_sat", bus4.fg_count, 32'd15);

    repeat (3) pixel(1'b1, 24'hFFFFFF, 24'h000000);
    vsync_block(10'd765);
    repeat (3) pixel(1'b1, 24'hFFFFFF, 24'h000000);

    for (int f = 0; f < 6; f++) begin
      vsync_block(10'($urandom_range(0, 765)));
      random_frame(3, 40);
    end

    // Reset in the middle of a frame, then recover from a fresh start.
    vsync_block(10'd200);
    random_frame(1, 30);
    apply_reset();
    repeat (3) pixel(1'b1, 24'hFFFFFF, 24'h000000);
    vsync_block(10'd30);
    random_frame(2, 30);
    vsync_block(10'd300);
    random_frame(2, 30);
    vsync_block(10'd400);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 10'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
